// File: rtl/timer_regs_mc_if.sv
// ============================================================================
// Module      : timer_regs_mc_if
// Description : Register-access bus between the APB slave and timer_regs_mc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_regs_mc_if #(
  parameter int ADDR_SIZE = 12,
  parameter int DATA_SIZE = 32
);
  logic                   wr_en;
  logic                   rd_en;
  logic [ADDR_SIZE-1:0]   addr;
  logic [DATA_SIZE-1:0]   wdata;
  logic [DATA_SIZE/8-1:0] pstrb;
  logic [DATA_SIZE-1:0]   rdata;
  logic                   err_en;

  modport master (
    output wr_en, rd_en, addr, wdata, pstrb,
    input  rdata, err_en
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata, pstrb,
    output rdata, err_en
  );
endinterface

`default_nettype wire

// File: rtl/timer_regs_mc.sv
// ============================================================================
// Module      : timer_regs_mc
// Description : Multi-channel system-timer register file (TCR, counter window,
//               NUM_CMP 64-bit compare channels). Optional macro
//               TIMER_CMP_RELOAD_EN adds PRD/CMODE periodic auto-reload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_regs_mc #(
  parameter int ADDR_SIZE    = 12,
  parameter int DATA_SIZE    = 32,
  parameter int NUM_CMP      = 4,
  parameter int DIV_VAL_SIZE = 4,
  parameter int DIV_MAX      = 8
) (
  input  wire logic                    sys_clk,
  input  wire logic                    sys_rst_n,
  timer_regs_mc_if.slave               bus,
  input  wire logic [63:0]             cnt,
  input  wire logic                    dbg_mode,
  output logic                         timer_en,
  output logic                         div_en,
  output logic [DIV_VAL_SIZE-1:0]      div_val,
  output logic                         halt_req_out,
  output logic                         cnt_wr_lo,
  output logic                         cnt_wr_hi,
  output logic [31:0]                  wdata_counter,
  output logic                         irq,
  output logic [NUM_CMP-1:0]           irq_vec
);

  localparam logic [ADDR_SIZE-1:0]    c_addr_tcr   = ADDR_SIZE'('h00);
  localparam logic [ADDR_SIZE-1:0]    c_addr_tdr0  = ADDR_SIZE'('h04);
  localparam logic [ADDR_SIZE-1:0]    c_addr_tdr1  = ADDR_SIZE'('h08);
  localparam logic [ADDR_SIZE-1:0]    c_addr_tier  = ADDR_SIZE'('h0C);
  localparam logic [ADDR_SIZE-1:0]    c_addr_tisr  = ADDR_SIZE'('h10);
  localparam logic [ADDR_SIZE-1:0]    c_addr_thcsr = ADDR_SIZE'('h14);
  localparam logic [DIV_VAL_SIZE-1:0] c_div_max    = DIV_VAL_SIZE'(DIV_MAX);
  localparam logic [DIV_VAL_SIZE-1:0] c_div_rst    = DIV_VAL_SIZE'(1);

  // --------------------------------------------------------------------------
  // Common write decode
  // --------------------------------------------------------------------------
  logic [31:0] w_mask;
  logic        w_wr_tcr;
  logic        w_wr_tdr0;
  logic        w_wr_tdr1;
  logic        w_wr_tier;
  logic        w_wr_tisr;
  logic        w_wr_thcsr;

  assign w_mask     = {{8{bus.pstrb[3]}}, {8{bus.pstrb[2]}},
                       {8{bus.pstrb[1]}}, {8{bus.pstrb[0]}}};
  assign w_wr_tcr   = bus.wr_en && (bus.addr == c_addr_tcr);
  assign w_wr_tdr0  = bus.wr_en && (bus.addr == c_addr_tdr0);
  assign w_wr_tdr1  = bus.wr_en && (bus.addr == c_addr_tdr1);
  assign w_wr_tier  = bus.wr_en && (bus.addr == c_addr_tier);
  assign w_wr_tisr  = bus.wr_en && (bus.addr == c_addr_tisr);
  assign w_wr_thcsr = bus.wr_en && (bus.addr == c_addr_thcsr);

  // --------------------------------------------------------------------------
  // TCR
  // --------------------------------------------------------------------------
  logic                    r_timer_en;
  logic                    r_div_en;
  logic [DIV_VAL_SIZE-1:0] r_div_val;
  logic                    w_new_timer_en;
  logic                    w_new_div_en;
  logic [DIV_VAL_SIZE-1:0] w_new_div_val;
  logic                    w_tcr_err;
  logic [31:0]             w_tcr_rd;

  assign w_new_timer_en = bus.pstrb[0] ? bus.wdata[0] : r_timer_en;
  assign w_new_div_en   = bus.pstrb[0] ? bus.wdata[1] : r_div_en;
  assign w_new_div_val  = bus.pstrb[1] ? bus.wdata[8 +: DIV_VAL_SIZE] : r_div_val;

  // The divider may only be reconfigured while the timer is stopped.
  assign w_tcr_err = (bus.pstrb[1] && (w_new_div_val > c_div_max)) ||
                     (r_timer_en && ((w_new_div_en != r_div_en) ||
                                     (w_new_div_val != r_div_val)));

  always_comb begin
    w_tcr_rd                       = '0;
    w_tcr_rd[0]                    = r_timer_en;
    w_tcr_rd[1]                    = r_div_en;
    w_tcr_rd[8 +: DIV_VAL_SIZE]    = r_div_val;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_timer_en <= 1'b0;
      r_div_en   <= 1'b0;
      r_div_val  <= c_div_rst;
    end else if (w_wr_tcr && !w_tcr_err) begin
      r_timer_en <= w_new_timer_en;
      r_div_en   <= w_new_div_en;
      r_div_val  <= w_new_div_val;
    end
  end

  assign timer_en    = r_timer_en;
  assign div_en      = r_div_en;
  assign div_val     = r_div_val;
  assign bus.err_en  = w_wr_tcr && w_tcr_err;

  // --------------------------------------------------------------------------
  // Counter load window
  // --------------------------------------------------------------------------
  logic [31:0] w_cnt_half;

  assign w_cnt_half    = w_wr_tdr1 ? cnt[63:32] : cnt[31:0];
  assign wdata_counter = (w_cnt_half & ~w_mask) | (bus.wdata & w_mask);
  assign cnt_wr_lo     = w_wr_tdr0;
  assign cnt_wr_hi     = w_wr_tdr1;

  // --------------------------------------------------------------------------
  // Compare channels
  // --------------------------------------------------------------------------
  logic [NUM_CMP-1:0] w_match;
  logic [NUM_CMP-1:0] w_rise;
  logic [31:0]        w_ch_rd [NUM_CMP];

  for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_ch
    localparam logic [ADDR_SIZE-5:0] c_slot = (ADDR_SIZE-4)'(gi + 2);

    logic        w_sel;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_wr_prd;
    logic        w_wr_cmode;
    logic        w_periodic;
    logic        w_reload;
    logic [31:0] w_prd_rd;
    logic [63:0] w_cmp_reload;
    logic [63:0] r_cmp;
    logic        r_match_q;

    assign w_sel      = (bus.addr[ADDR_SIZE-1:4] == c_slot) && (bus.addr[1:0] == 2'b00);
    assign w_wr_lo    = bus.wr_en && w_sel && (bus.addr[3:2] == 2'd0);
    assign w_wr_hi    = bus.wr_en && w_sel && (bus.addr[3:2] == 2'd1);
    assign w_wr_prd   = bus.wr_en && w_sel && (bus.addr[3:2] == 2'd2);
    assign w_wr_cmode = bus.wr_en && w_sel && (bus.addr[3:2] == 2'd3);

    assign w_match[gi] = (r_cmp == cnt);
    assign w_rise[gi]  = w_match[gi] && !r_match_q;

`ifdef TIMER_CMP_RELOAD_EN
    logic [31:0] r_prd;
    logic        r_cmode;

    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        r_prd   <= '0;
        r_cmode <= 1'b0;
      end else begin
        if (w_wr_prd)
          r_prd <= (r_prd & ~w_mask) | (bus.wdata & w_mask);
        if (w_wr_cmode && bus.pstrb[0])
          r_cmode <= bus.wdata[0];
      end
    end

    assign w_periodic   = r_cmode;
    assign w_prd_rd     = r_prd;
    assign w_cmp_reload = r_cmp + {32'd0, r_prd};
`else
    logic w_unused_wr;

    assign w_unused_wr  = w_wr_prd | w_wr_cmode;
    assign w_periodic   = 1'b0;
    assign w_prd_rd     = '0;
    assign w_cmp_reload = r_cmp;
`endif

    // A software write to either compare half suppresses the reload.
    assign w_reload = w_rise[gi] && w_periodic && !w_wr_lo && !w_wr_hi;

    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        r_cmp     <= '1;
        r_match_q <= 1'b0;
      end else begin
        r_match_q <= w_match[gi];
        if (w_reload) begin
          r_cmp <= w_cmp_reload;
        end else begin
          if (w_wr_lo)
            r_cmp[31:0]  <= (r_cmp[31:0]  & ~w_mask) | (bus.wdata & w_mask);
          if (w_wr_hi)
            r_cmp[63:32] <= (r_cmp[63:32] & ~w_mask) | (bus.wdata & w_mask);
        end
      end
    end

    assign w_ch_rd[gi] = !w_sel                    ? 32'd0        :
                         (bus.addr[3:2] == 2'd0)   ? r_cmp[31:0]  :
                         (bus.addr[3:2] == 2'd1)   ? r_cmp[63:32] :
                         (bus.addr[3:2] == 2'd2)   ? w_prd_rd     :
                                                     {31'd0, w_periodic};
  end

  // --------------------------------------------------------------------------
  // Interrupt enable / status
  // --------------------------------------------------------------------------
  logic [NUM_CMP-1:0] r_tier;
  logic [NUM_CMP-1:0] r_tisr;
  logic [NUM_CMP-1:0] w_tisr_clr;

  assign w_tisr_clr = w_wr_tisr ? (bus.wdata[NUM_CMP-1:0] & w_mask[NUM_CMP-1:0])
                                : '0;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_tier <= '0;
      r_tisr <= '0;
    end else begin
      if (w_wr_tier)
        r_tier <= (r_tier & ~w_mask[NUM_CMP-1:0]) |
                  (bus.wdata[NUM_CMP-1:0] & w_mask[NUM_CMP-1:0]);
      // A new match edge in the clearing cycle keeps the bit set.
      r_tisr <= (r_tisr & ~w_tisr_clr) | w_rise;
    end
  end

  assign irq_vec = r_tisr & r_tier;
  assign irq     = |irq_vec;

  // --------------------------------------------------------------------------
  // Halt control
  // --------------------------------------------------------------------------
  logic r_halt_req;
  logic w_halt_ack;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      r_halt_req <= 1'b0;
    else if (w_wr_thcsr && bus.pstrb[0])
      r_halt_req <= bus.wdata[0];
  end

  assign w_halt_ack   = dbg_mode && r_halt_req;
  assign halt_req_out = w_halt_ack;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (bus.rd_en) begin
      case (bus.addr)
        c_addr_tcr:   w_rdata = w_tcr_rd;
        c_addr_tdr0:  w_rdata = cnt[31:0];
        c_addr_tdr1:  w_rdata = cnt[63:32];
        c_addr_tier:  w_rdata[NUM_CMP-1:0] = r_tier;
        c_addr_tisr:  w_rdata[NUM_CMP-1:0] = r_tisr;
        c_addr_thcsr: w_rdata[1:0] = {w_halt_ack, r_halt_req};
        default: begin
          for (int i = 0; i < NUM_CMP; i++)
            w_rdata = w_rdata | w_ch_rd[i];
        end
      endcase
    end
  end

  assign bus.rdata = w_rdata;

endmodule

`default_nettype wire

// File: tb/tb_timer_regs_mc.sv
// ============================================================================
// Module      : tb_timer_regs_mc
// Description : Directed self-checking bench for timer_regs_mc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_regs_mc;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [63:0] cnt;
  logic        dbg_mode;
  logic        timer_en, div_en, halt_req_out, cnt_wr_lo, cnt_wr_hi, irq;
  logic [3:0]  div_val;
  logic [31:0] wdata_counter;
  logic [3:0]  irq_vec;

  int n_pass  = 0;
  int n_total = 0;

  timer_regs_mc_if #(.ADDR_SIZE(12), .DATA_SIZE(32)) bus ();

  timer_regs_mc dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .bus           (bus),
    .cnt           (cnt),
    .dbg_mode      (dbg_mode),
    .timer_en      (timer_en),
    .div_en        (div_en),
    .div_val       (div_val),
    .halt_req_out  (halt_req_out),
    .cnt_wr_lo     (cnt_wr_lo),
    .cnt_wr_hi     (cnt_wr_hi),
    .wdata_counter (wdata_counter),
    .irq           (irq),
    .irq_vec       (irq_vec)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic err);
    bus.addr  = a;
    bus.wdata = d;
    bus.pstrb = s;
    bus.wr_en = 1'b1;
    #1;
    err = bus.err_en;
    tick();
    bus.wr_en = 1'b0;
    bus.pstrb = 4'h0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    #1;
    d = bus.rdata;
    bus.rd_en = 1'b0;
    #1;
  endtask

  initial begin
    logic        e;
    logic [31:0] r;

    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0; bus.pstrb = '0;
    cnt = 64'd0; dbg_mode = 1'b0; sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Reset state
    chk("rst_irq", irq, 0);
    chk("rst_irq_vec", irq_vec, 0);
    chk("rst_timer_en", timer_en, 0);
    chk("rst_div_en", div_en, 0);
    chk("rst_div_val", div_val, 1);
    chk("rst_halt", halt_req_out, 0);
    rd(12'h000, r); chk("rst_tcr", r, 32'h0000_0100);
    rd(12'h020, r); chk("rst_cmpl0", r, 32'hFFFF_FFFF);
    rd(12'h02C, r); chk("rst_cmode0", r, 0);

    // TCR error handling
    wr(12'h000, 32'h0000_0903, 4'hF, e); chk("tcr_err_divmax", e, 1);
    rd(12'h000, r); chk("tcr_after_err", r, 32'h0000_0100);
    chk("tcr_err_timer_en", timer_en, 0);
    wr(12'h000, 32'h0000_0303, 4'hF, e); chk("tcr_ok_err", e, 0);
    rd(12'h000, r); chk("tcr_ok_rd", r, 32'h0000_0303);
    chk("tcr_div_val3", div_val, 3);
    wr(12'h000, 32'h0000_0203, 4'hF, e); chk("tcr_err_running", e, 1);
    chk("tcr_div_val_kept", div_val, 3);
    chk("tcr_timer_en_kept", timer_en, 1);
    wr(12'h000, 32'h0000_0302, 4'hF, e); chk("tcr_stop_err", e, 0);
    chk("tcr_stopped", timer_en, 0);

    // Counter window
    cnt = 64'h1234_5678_9ABC_DEF0;
    bus.addr = 12'h004; bus.wdata = 32'hAAAA_BBBB; bus.pstrb = 4'b0011; bus.wr_en = 1'b1;
    #1;
    chk("tdr0_wr_lo", cnt_wr_lo, 1);
    chk("tdr0_wr_hi", cnt_wr_hi, 0);
    chk("tdr0_merge", wdata_counter, 32'h9ABC_BBBB);
    bus.addr = 12'h008; bus.pstrb = 4'b1000;
    #1;
    chk("tdr1_wr_hi", cnt_wr_hi, 1);
    chk("tdr1_merge", wdata_counter, 32'hAA34_5678);
    tick();
    bus.wr_en = 1'b0; bus.pstrb = 4'h0;
    rd(12'h008, r); chk("tdr1_rd", r, 32'h1234_5678);
    bus.addr = 12'h008; #1; chk("rdata_idle", bus.rdata, 0);

    // Channel 0 one-shot match and W1C
    wr(12'h020, 32'h0000_0005, 4'hF, e);
    wr(12'h024, 32'h0000_0001, 4'hF, e);
    wr(12'h00C, 32'h0000_0001, 4'hF, e);
    cnt = 64'h0000_0001_0000_0004;
    tick();
    rd(12'h010, r); chk("tisr_before", r, 0);
    cnt = 64'h0000_0001_0000_0005;
    tick();
    chk("irq_match", irq, 1);
    chk("irq_vec_match", irq_vec, 4'b0001);
    rd(12'h010, r); chk("tisr_match", r, 1);
    wr(12'h010, 32'h0000_0001, 4'hF, e);
    rd(12'h010, r); chk("tisr_cleared", r, 0);
    chk("irq_cleared", irq, 0);
    tick(); tick();
    rd(12'h010, r); chk("tisr_hold", r, 0);
    cnt = 64'h0000_0001_0000_0006; tick();
    cnt = 64'h0000_0001_0000_0005; tick();
    chk("irq_rematch", irq, 1);
    wr(12'h00C, 32'h0000_0000, 4'hF, e);
    chk("irq_masked", irq, 0);
    rd(12'h010, r); chk("tisr_masked_kept", r, 1);
    wr(12'h010, 32'h0000_0001, 4'hF, e);

    // Byte-strobed compare write, unmapped space
    wr(12'h040, 32'h0000_AB00, 4'b0010, e);
    rd(12'h040, r); chk("cmpl2_strb", r, 32'hFFFF_ABFF);
    rd(12'h044, r); chk("cmph2_kept", r, 32'hFFFF_FFFF);
    wr(12'h060, 32'h1234_5678, 4'hF, e); chk("ch4_no_err", e, 0);
    rd(12'h060, r); chk("ch4_rd", r, 0);
    rd(12'h018, r); chk("unmapped_rd", r, 0);

    // Channel 1 periodic reload / one-shot fallback
    wr(12'h038, 32'h0000_0020, 4'hF, e);
    wr(12'h03C, 32'h0000_0001, 4'hF, e);
    wr(12'h030, 32'hFFFF_FFF0, 4'hF, e);
    wr(12'h00C, 32'h0000_0002, 4'hF, e);
    cnt = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    rd(12'h010, r); chk("ch1_tisr", r, 32'h2);
    chk("ch1_irq", irq, 1);
`ifdef TIMER_CMP_RELOAD_EN
    rd(12'h038, r); chk("ch1_prd", r, 32'h20);
    rd(12'h03C, r); chk("ch1_cmode", r, 32'h1);
    rd(12'h030, r); chk("ch1_cmpl_reload", r, 32'h0000_0010);
    rd(12'h034, r); chk("ch1_cmph_reload", r, 32'h0000_0000);
    tick();
    cnt = 64'h0000_0000_0000_0010;
    wr(12'h010, 32'h0000_0002, 4'hF, e);
    rd(12'h010, r); chk("ch1_set_wins", r, 32'h2);
    rd(12'h030, r); chk("ch1_cmpl_reload2", r, 32'h0000_0030);
`else
    rd(12'h038, r); chk("ch1_prd_zero", r, 0);
    rd(12'h03C, r); chk("ch1_cmode_zero", r, 0);
    rd(12'h030, r); chk("ch1_cmpl_oneshot", r, 32'hFFFF_FFF0);
    rd(12'h034, r); chk("ch1_cmph_oneshot", r, 32'hFFFF_FFFF);
    cnt = 64'd0;
    tick();
    cnt = 64'hFFFF_FFFF_FFFF_FFF0;
    wr(12'h010, 32'h0000_0002, 4'hF, e);
    rd(12'h010, r); chk("ch1_set_wins", r, 32'h2);
`endif

    // Halt handshake
    wr(12'h014, 32'h0000_0001, 4'hF, e);
    rd(12'h014, r); chk("thcsr_nodbg", r, 32'h1);
    chk("halt_nodbg", halt_req_out, 0);
    dbg_mode = 1'b1;
    #1;
    rd(12'h014, r); chk("thcsr_dbg", r, 32'h3);
    chk("halt_dbg", halt_req_out, 1);

    // Mid-operation reset
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk("mrst_irq", irq, 0);
    chk("mrst_halt", halt_req_out, 0);
    chk("mrst_div_val", div_val, 1);
    rd(12'h010, r); chk("mrst_tisr", r, 0);
    rd(12'h030, r); chk("mrst_cmpl1", r, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
